// File: rtl/run_sequencer.sv
// -----------------------------------------------------------------------------
// run_sequencer
//
// Run controller for the 8-bit single-cycle core and its data memory. The core
// is held in reset while the host owns the single data-memory port. On start
// the memory port is handed to the core, core reset is released, and RUN
// cycles are counted until the core reports done (or, optionally, a timeout).
//
// Optional feature macro: RUN_SEQ_TIMEOUT_EN
//   defined   : RUN aborts to FAULT after MAX_CYCLES cycles without core_done
//   undefined : RUN exits only on core_done, timeout is tied low and the
//               cycle counter saturates at all ones
//
// Ports
//   clk, reset                   : clock, synchronous active-high reset
//   start                        : host run request (level, sampled each cycle)
//   host_wen/ren/addr/wdata      : host memory request
//   host_rdata                   : host read data (0 while the core owns memory)
//   core_wen/ren/addr/wdata      : core memory request
//   core_rdata                   : core read data (0 while the host owns memory)
//   mem_wen/ren/addr/wdata       : muxed request to the data memory
//   mem_rdata                    : combinational read data from the memory
//   core_reset                   : reset to the core (high outside RUN)
//   core_done                    : done flag from the core
//   busy / run_done / timeout    : state flags for RUN / DONE / FAULT
//   host_err                     : one-cycle pulse after a host access in RUN
//   cycle_count                  : RUN cycles of the current or last run
//
// The counter compare is done on 64 bits so MAX_CYCLES values larger than the
// counter range still behave (the counter then saturates); CW must be < 64.
// -----------------------------------------------------------------------------
module run_sequencer #(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int CW         = 16,
    parameter int MAX_CYCLES = 1000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          host_wen,
    input  logic          host_ren,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic [DW-1:0] host_rdata,
    input  logic          core_wen,
    input  logic          core_ren,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    output logic          mem_wen,
    output logic          mem_ren,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          core_reset,
    input  logic          core_done,
    output logic          busy,
    output logic          run_done,
    output logic          timeout,
    output logic          host_err,
    output logic [CW-1:0] cycle_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

`ifdef RUN_SEQ_TIMEOUT_EN
    localparam logic TIMEOUT_EN = 1'b1;
`else
    localparam logic TIMEOUT_EN = 1'b0;
`endif

    localparam logic [CW-1:0] CNT_ALL_ONES = {CW{1'b1}};
    localparam logic [63:0]   CNT_MAX_WIDE = {{(64-CW){1'b0}}, {CW{1'b1}}};
    localparam logic [63:0]   MAX_WIDE     = 64'(MAX_CYCLES);
    localparam logic [63:0]   LAST_WIDE    = MAX_WIDE - 64'd1;
    // Value loaded on timeout; clipped to all ones if MAX_CYCLES does not fit.
    localparam logic [CW-1:0] FAULT_COUNT  = (MAX_WIDE > CNT_MAX_WIDE) ?
                                             CNT_ALL_ONES : MAX_WIDE[CW-1:0];

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          host_err_q, host_err_d;
    logic          last_cycle_s;
    logic [CW-1:0] count_inc_s;
    logic          core_owns_s;

    assign last_cycle_s = ({{(64-CW){1'b0}}, count_q} == LAST_WIDE);
    assign count_inc_s  = (count_q == CNT_ALL_ONES) ? count_q
                                                    : (count_q + {{(CW-1){1'b0}}, 1'b1});

    // State, counter and error-pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            count_q    <= {CW{1'b0}};
            host_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            host_err_q <= host_err_d;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        host_err_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_FAULT: begin
                if (start) begin
                    state_d = ST_RUN;
                    count_d = {CW{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                // Host access while the core owns memory is dropped and flagged.
                host_err_d = host_wen | host_ren;
                // core_done has priority over the timeout in the same cycle.
                if (core_done) begin
                    state_d = ST_DONE;
                end else if (TIMEOUT_EN && last_cycle_s) begin
                    state_d = ST_FAULT;
                    count_d = FAULT_COUNT;
                end else begin
                    count_d = count_inc_s;
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = {CW{1'b0}};
            end
        endcase
    end

    // Memory port mux, selected by the state register only.
    always_comb begin
        if (core_owns_s) begin
            mem_wen    = core_wen;
            mem_ren    = core_ren;
            mem_addr   = core_addr;
            mem_wdata  = core_wdata;
            core_rdata = mem_rdata;
            host_rdata = {DW{1'b0}};
        end else begin
            mem_wen    = host_wen;
            mem_ren    = host_ren;
            mem_addr   = host_addr;
            mem_wdata  = host_wdata;
            core_rdata = {DW{1'b0}};
            host_rdata = mem_rdata;
        end
    end

    assign core_owns_s = (state_q == ST_RUN);
    assign core_reset  = ~core_owns_s;
    assign busy        = core_owns_s;
    assign run_done    = (state_q == ST_DONE);
    assign timeout     = TIMEOUT_EN & (state_q == ST_FAULT);
    assign host_err    = host_err_q;
    assign cycle_count = count_q;

endmodule

// File: tb/tb_run_sequencer.sv
// -----------------------------------------------------------------------------
// tb_run_sequencer
//
// Directed bench for run_sequencer with MAX_CYCLES=10 and a small behavioural
// data memory. Inputs change 1 time unit after the rising edge and outputs are
// sampled a few units later, well away from the edge. The timeout scenario
// follows the RUN_SEQ_TIMEOUT_EN build setting.
// -----------------------------------------------------------------------------
module tb_run_sequencer;

    logic        clk = 1'b0;
    logic        reset, start;
    logic        host_wen, host_ren;
    logic [7:0]  host_addr, host_wdata, host_rdata;
    logic        core_wen, core_ren;
    logic [7:0]  core_addr, core_wdata, core_rdata;
    logic        mem_wen, mem_ren;
    logic [7:0]  mem_addr, mem_wdata, mem_rdata;
    logic        core_reset, core_done;
    logic        busy, run_done, timeout, host_err;
    logic [15:0] cycle_count;

    logic [7:0]  mem [0:255];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    run_sequencer #(.AW(8), .DW(8), .CW(16), .MAX_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start),
        .host_wen(host_wen), .host_ren(host_ren), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata),
        .core_wen(core_wen), .core_ren(core_ren), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata),
        .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .core_reset(core_reset), .core_done(core_done),
        .busy(busy), .run_done(run_done), .timeout(timeout),
        .host_err(host_err), .cycle_count(cycle_count)
    );

    // Behavioural data memory: synchronous write, combinational read.
    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Watchdog in case the sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[5] = 8'hA5;
        reset = 1'b1; start = 1'b0;
        host_wen = 1'b0; host_ren = 1'b0; host_addr = 8'h05; host_wdata = 8'h00;
        core_wen = 1'b0; core_ren = 1'b0; core_addr = 8'h00; core_wdata = 8'h00;
        core_done = 1'b0;
        tick(2);
        #1;
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_run_done", 32'(run_done), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_host_err", 32'(host_err), 32'd0);
        chk("rst_count", 32'(cycle_count), 32'd0);
        chk("rst_host_rdata", 32'(host_rdata), 32'hA5);
        chk("rst_core_rdata", 32'(core_rdata), 32'd0);

        // Host load and read-back in IDLE.
        reset = 1'b0;
        host_wen = 1'b1; host_addr = 8'h00; host_wdata = 8'h3C;
        #1 chk("idle_mem_wen", 32'(mem_wen), 32'd1);
        tick(1);
        host_wen = 1'b0; host_ren = 1'b1;
        #1;
        chk("idle_rd", 32'(host_rdata), 32'h3C);
        chk("idle_core_reset", 32'(core_reset), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        host_ren = 1'b0;

        // Normal run, core_done in the 5th RUN cycle.
        start = 1'b1; core_ren = 1'b1; core_addr = 8'h00;
        tick(1);
        start = 1'b0;
        #1;
        chk("run_core_reset", 32'(core_reset), 32'd0);
        chk("run_core_rdata", 32'(core_rdata), 32'h3C);
        chk("run_host_rdata", 32'(host_rdata), 32'd0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("run_count", 32'(cycle_count), 32'(i));
            chk("run_busy", 32'(busy), 32'd1);
            if (i == 4) core_done = 1'b1;
            tick(1);
        end
        core_done = 1'b0; core_ren = 1'b0;
        #1;
        chk("done_run_done", 32'(run_done), 32'd1);
        chk("done_core_reset", 32'(core_reset), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_count", 32'(cycle_count), 32'd4);
        chk("done_core_rdata", 32'(core_rdata), 32'd0);

        // Preload 0x80, then try to overwrite it from the host during RUN.
        host_wen = 1'b1; host_addr = 8'h80; host_wdata = 8'h11;
        tick(1);
        host_wen = 1'b0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        host_wen = 1'b1; host_addr = 8'h80; host_wdata = 8'hEE; core_wen = 1'b0;
        #1;
        chk("hosterr_mem_wen", 32'(mem_wen), 32'd0);
        chk("hosterr_pre", 32'(host_err), 32'd0);
        tick(1);
        host_wen = 1'b0;
        #1;
        chk("hosterr_pulse", 32'(host_err), 32'd1);
        chk("hosterr_count", 32'(cycle_count), 32'd1);
        tick(1);
        #1 chk("hosterr_clear", 32'(host_err), 32'd0);

        // Reset in the 3rd RUN cycle.
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        #1;
        chk("midrst_core_reset", 32'(core_reset), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_count", 32'(cycle_count), 32'd0);
        chk("midrst_run_done", 32'(run_done), 32'd0);
        host_ren = 1'b1; host_addr = 8'h80;
        #1 chk("mem80_unchanged", 32'(host_rdata), 32'h11);
        host_ren = 1'b0;

        // A run after the reset behaves normally.
        start = 1'b1;
        tick(1);
        start = 1'b0;
        #1 chk("rerun_busy", 32'(busy), 32'd1);
        tick(1);
        core_done = 1'b1;
        #1 chk("rerun_count", 32'(cycle_count), 32'd1);
        tick(1);
        core_done = 1'b0;
        #1;
        chk("rerun_done", 32'(run_done), 32'd1);
        chk("rerun_count_frz", 32'(cycle_count), 32'd1);

        // core_done held low.
        start = 1'b1;
        tick(1);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1 chk("to_count", 32'(cycle_count), 32'(i));
            tick(1);
        end
        #1;
`ifdef RUN_SEQ_TIMEOUT_EN
        chk("to_timeout", 32'(timeout), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);
        chk("to_count_final", 32'(cycle_count), 32'd10);
        chk("to_core_reset", 32'(core_reset), 32'd1);
        chk("to_run_done", 32'(run_done), 32'd0);
`else
        tick(10);
        #1;
        chk("nto_busy", 32'(busy), 32'd1);
        chk("nto_count", 32'(cycle_count), 32'd20);
        chk("nto_timeout", 32'(timeout), 32'd0);
        core_done = 1'b1;
        tick(1);
        core_done = 1'b0;
        #1 chk("nto_done", 32'(run_done), 32'd1);
`endif

        // core_done in the same cycle the count reaches MAX_CYCLES-1.
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(9);
        #1 chk("race_count", 32'(cycle_count), 32'd9);
        core_done = 1'b1;
        tick(1);
        core_done = 1'b0;
        #1;
        chk("race_done", 32'(run_done), 32'd1);
        chk("race_timeout", 32'(timeout), 32'd0);
        chk("race_count_frz", 32'(cycle_count), 32'd9);
        chk("race_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
